// File: rtl/dmem_pkg.sv
// Shared definitions for the APB data-memory responder.
//   dmem_state_e     : responder FSM states (IDLE, WAIT, DONE)
//   DMEM_BASE        : byte address of the first word of the window
//   DMEM_DEPTH_WORDS : default number of 32-bit words in the window
//   DMEM_ADDR_W      : APB byte-address width
//   dmem_eff_wait()  : wait states actually inserted per transfer
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

  localparam logic [11:0] DMEM_BASE        = 12'h000;
  localparam int          DMEM_DEPTH_WORDS = 256;
  localparam int          DMEM_ADDR_W      = 12;

  // Wait states collapse to zero when the wait feature is not built in.
  function automatic int dmem_eff_wait(input int cfg, input bit en);
    return en ? cfg : 0;
  endfunction

endpackage

// File: rtl/dmem_sram_array.sv
// Byte-enabled single-port synchronous RAM, one 32-bit word per address.
// No reset: contents are undefined until written.
//   clk_i   : clock, rising edge
//   we_i    : write enable (qualified per lane by be_i)
//   be_i    : byte lane enables, bit n covers wdata_i[8n+7:8n]
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : registered read data (word at addr_i on the previous edge)
module dmem_sram_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i && be_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    // Read-before-write on the same address; the responder never reads
    // and writes in the same cycle, so this ordering is not observable.
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/apb_dmem_responder.sv
// APB responder for the CPU data-memory window (DEPTH_WORDS*4 bytes).
// SETUP/ACCESS handshake, optional wait states, byte-strobed writes, and
// pslverr for misaligned or out-of-window accesses.
// Optional feature macro: DMEM_WAIT_EN -- when defined, WAIT_CYCLES wait
// states are inserted per transfer; otherwise every transfer is 2 cycles.
//   clk_i, rst_i         : clock, synchronous active-high reset
//   psel_i, penable_i    : APB select / access phase
//   pwrite_i, paddr_i    : direction, byte address
//   pwdata_i, pstrb_i    : write data and byte lane enables
//   prdata_o             : read data, nonzero only in the completion cycle
//   pready_o, pslverr_o  : completion and error, registered
module apb_dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   psel_i,
  input  logic                   penable_i,
  input  logic                   pwrite_i,
  input  logic [DMEM_ADDR_W-1:0] paddr_i,
  input  logic [31:0]            pwdata_i,
  input  logic [3:0]             pstrb_i,
  output logic [31:0]            prdata_o,
  output logic                   pready_o,
  output logic                   pslverr_o
);

`ifdef DMEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif
  localparam int W_EFF = dmem_eff_wait(WAIT_CYCLES, WAIT_EN);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  dmem_state_e           state_q, state_d;
  logic [IDX_W-1:0]      addr_q, addr_d;
  logic                  write_q, write_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            strb_q, strb_d;
  logic                  err_q, err_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic                  rd_valid_q, rd_valid_d;
`ifdef DMEM_WAIT_EN
  logic [3:0]            cnt_q, cnt_d;
`endif

  logic [DMEM_ADDR_W-1:0] off;
  logic                   ram_we;
  logic [IDX_W-1:0]       ram_addr;
  logic [31:0]            ram_rdata;

  assign off = paddr_i - DMEM_BASE;

  // The RAM read must be issued on the edge that enters DONE. From IDLE
  // (no wait states) the address is still only on paddr_i; from WAIT it
  // has already been latched.
  assign ram_addr = (state_q == IDLE) ? off[2 +: IDX_W] : addr_q;
  assign ram_we   = (state_q == DONE) && psel_i && penable_i &&
                    write_q && !err_q && !rst_i;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    err_d   = err_q;
`ifdef DMEM_WAIT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (psel_i && !penable_i) begin
          addr_d  = off[2 +: IDX_W];
          write_d = pwrite_i;
          wdata_d = pwdata_i;
          strb_d  = pstrb_i;
          err_d   = (off[1:0] != 2'b00) ||
                    (int'(off[DMEM_ADDR_W-1:2]) >= DEPTH_WORDS);
          if (W_EFF == 0) begin
            state_d = DONE;
          end else begin
`ifdef DMEM_WAIT_EN
            state_d = WAIT;
            cnt_d   = 4'(W_EFF);
`endif
          end
        end
      end
`ifdef DMEM_WAIT_EN
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (!psel_i || !penable_i) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d = DONE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    pready_d   = (state_d == DONE);
    pslverr_d  = pready_d && err_d;
    rd_valid_d = pready_d && !err_d && !write_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      strb_q     <= '0;
      err_q      <= 1'b0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      rd_valid_q <= 1'b0;
`ifdef DMEM_WAIT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      err_q      <= err_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      rd_valid_q <= rd_valid_d;
`ifdef DMEM_WAIT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  dmem_sram_array #(
    .DEPTH (DEPTH_WORDS),
    .AW    (IDX_W)
  ) u_sram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .be_i    (strb_q),
    .addr_i  (ram_addr),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  // Both terms are flops; the gate keeps prdata_o at zero outside a
  // successful read completion without adding a cycle of latency.
  assign prdata_o  = rd_valid_q ? ram_rdata : 32'h0;
  assign pready_o  = pready_q;
  assign pslverr_o = pslverr_q;

endmodule

// File: tb/tb_apb_dmem_responder.sv
module tb_apb_dmem_responder;

`ifdef DMEM_WAIT_EN
  localparam int W = 2;
`else
  localparam int W = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  logic        psel_i, penable_i, pwrite_i;
  logic [11:0] paddr_i;
  logic [31:0] pwdata_i;
  logic [3:0]  pstrb_i;
  logic [31:0] prdata_o;
  logic        pready_o, pslverr_o;

  always #5 clk = ~clk;

  apb_dmem_responder #(
    .DEPTH_WORDS (256),
    .WAIT_CYCLES (2)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .psel_i    (psel_i),
    .penable_i (penable_i),
    .pwrite_i  (pwrite_i),
    .paddr_i   (paddr_i),
    .pwdata_i  (pwdata_i),
    .pstrb_i   (pstrb_i),
    .prdata_o  (prdata_o),
    .pready_o  (pready_o),
    .pslverr_o (pslverr_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rdy_cnt = 0;

  // Expected outputs for the current cycle, set by the transaction driver
  // from the memory model; the compare process checks them every cycle.
  bit          chk_en = 1'b0;
  logic        exp_pready, exp_pslverr;
  logic [31:0] exp_prdata;
  logic [31:0] last_rdata;
  logic        last_err;

  logic [31:0] model_mem [256];

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      checks++;
      if (pready_o !== exp_pready) begin
        errors++;
        $display("FAIL pready cyc=%0d got=%0b exp=%0b", cyc, pready_o, exp_pready);
      end
      checks++;
      if (pslverr_o !== exp_pslverr) begin
        errors++;
        $display("FAIL pslverr cyc=%0d got=%0b exp=%0b", cyc, pslverr_o, exp_pslverr);
      end
      checks++;
      if (prdata_o !== exp_prdata) begin
        errors++;
        $display("FAIL prdata cyc=%0d got=%08h exp=%08h", cyc, prdata_o, exp_prdata);
      end
      if (pready_o === 1'b1) begin
        rdy_cnt++;
        last_rdata = prdata_o;
        last_err   = pslverr_o;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_idle();
    exp_pready  = 1'b0;
    exp_pslverr = 1'b0;
    exp_prdata  = 32'h0;
  endtask

  task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", name, got, exp);
    end
  endtask

  // drop: 0 = normal; k = access cycle (1..W+1) in which psel_i is low.
  task automatic xfer(input bit wr, input logic [11:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int drop, input bit rst_in_done);
    bit   err;
    bit   aborted;
    int   idx;
    err     = (a[1:0] != 2'b00) || (int'(a[11:2]) >= 256);
    idx     = int'(a[9:2]);
    aborted = 1'b0;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr;
    paddr_i = a; pwdata_i = d; pstrb_i = s;
    exp_idle();
    tick();
    for (int k = 1; k <= W + 1; k++) begin
      penable_i = 1'b1;
      psel_i    = (drop == k) ? 1'b0 : 1'b1;
      if (k == W + 1) begin
        exp_pready  = 1'b1;
        exp_pslverr = err;
        exp_prdata  = (err || wr) ? 32'h0 : model_mem[idx];
        if (rst_in_done) rst_i = 1'b1;
      end else begin
        exp_idle();
      end
      tick();
      if (drop == k && k <= W) begin
        aborted = 1'b1;
        break;
      end
    end
    psel_i = 1'b0; penable_i = 1'b0; rst_i = 1'b0;
    exp_idle();
    if (wr && !err && drop == 0 && !rst_in_done && !aborted) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
    end
    $display("xfer %s addr=%03h wdata=%08h strb=%04b drop=%0d rst=%0b err=%0b aborted=%0b",
             wr ? "WR" : "RD", a, d, s, drop, rst_in_done, err, aborted);
  endtask

  int rdy_before;

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
    rst_i = 1'b1; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    paddr_i = '0; pwdata_i = '0; pstrb_i = '0;
    last_rdata = '0; last_err = 1'b0;
    exp_idle();
    tick(); tick();
    chk_en = 1'b1;          // reset state: all outputs zero
    tick();
    rst_i = 1'b0;
    tick();

    xfer(1, 12'h000, 32'hDEADBEEF, 4'b1111, 0, 0);
    xfer(0, 12'h000, 32'h0, 4'b0000, 0, 0);
    check_lit("rd000", last_rdata, 32'hDEADBEEF);

    xfer(1, 12'h004, 32'h11223344, 4'b1111, 0, 0);
    xfer(1, 12'h004, 32'hAABBCCDD, 4'b0101, 0, 0);
    xfer(0, 12'h004, 32'h0, 4'b0000, 0, 0);
    check_lit("rd004_partial", last_rdata, 32'h11BB33DD);

    xfer(1, 12'h006, 32'hFFFFFFFF, 4'b1111, 0, 0);
    check_lit("wr006_err", {31'h0, last_err}, 32'h1);
    xfer(0, 12'h004, 32'h0, 4'b0000, 0, 0);
    check_lit("rd004_after_err", last_rdata, 32'h11BB33DD);
    xfer(0, 12'h400, 32'h0, 4'b0000, 0, 0);
    check_lit("rd400_err", {31'h0, last_err}, 32'h1);
    check_lit("rd400_data", last_rdata, 32'h0);

    xfer(1, 12'h004, 32'h99999999, 4'b0000, 0, 0);
    check_lit("wr004_nostrb_err", {31'h0, last_err}, 32'h0);
    xfer(0, 12'h004, 32'h0, 4'b0000, 0, 0);
    check_lit("rd004_nostrb", last_rdata, 32'h11BB33DD);

    xfer(1, 12'h3FC, 32'h5A5AA5A5, 4'b1111, 0, 0);
    xfer(0, 12'h3FC, 32'h0, 4'b0000, 0, 0);
    check_lit("rd3fc", last_rdata, 32'h5A5AA5A5);
    xfer(0, 12'h3FE, 32'h0, 4'b0000, 0, 0);
    check_lit("rd3fe_err", {31'h0, last_err}, 32'h1);

    xfer(1, 12'h008, 32'h01020304, 4'b1111, 0, 0);
    tick(); tick();
    rdy_before = rdy_cnt;
    xfer(1, 12'h008, 32'hCAFEF00D, 4'b1111, (W > 0) ? 2 : 1, 0);
    check_lit("abort_pready_cnt", 32'(rdy_cnt - rdy_before), (W > 0) ? 32'd0 : 32'd1);
    tick();
    xfer(0, 12'h008, 32'h0, 4'b0000, 0, 0);
    check_lit("rd008_after_abort", last_rdata, 32'h01020304);

    xfer(1, 12'h00C, 32'h0C0C0C0C, 4'b1111, 0, 0);
    xfer(1, 12'h00C, 32'h12345678, 4'b1111, 0, 1);
    tick();
    xfer(0, 12'h00C, 32'h0, 4'b0000, 0, 0);
    check_lit("rd00c_after_rst", last_rdata, 32'h0C0C0C0C);

    tick(); tick();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
